// File: rtl/escalonador_proc_pkg.sv
// Shared definitions for the round-robin process scheduler.
//   PC_W              : processor PC width
//   ID_SO/ID_P1/ID_P2 : context identifiers driven on id_proc
//   estado_t          : scheduler FSM encoding
package escalonador_proc_pkg;

    localparam int PC_W = 9;

    localparam logic [1:0] ID_SO = 2'b00;
    localparam logic [1:0] ID_P1 = 2'b01;
    localparam logic [1:0] ID_P2 = 2'b10;

    typedef enum logic [2:0] {
        OCIOSO,
        SELECIONA,
        CARREGA,
        EXECUTA,
        SALVA
    } estado_t;

endpackage

// File: rtl/escalonador_proc_contador_quantum.sv
// Time-slice counter.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   load, valor  : load the slice length (already clamped to >= 1)
//   dec          : decrement once per executing cycle
//   expira       : high during the last cycle of the slice
module contador_quantum (
    input  logic       clock,
    input  logic       reset,
    input  logic       load,
    input  logic       dec,
    input  logic [7:0] valor,
    output logic       expira
);

    logic [7:0] cnt;

    always_ff @(posedge clock) begin
        if (reset)
            cnt <= '0;
        else if (load)
            cnt <= valor;
        else if (dec && cnt != 8'd0)
            cnt <= cnt - 8'd1;
    end

    // Count of 1 means the current cycle is the final one of the slice.
    assign expira = (cnt == 8'd1);

endmodule

// File: rtl/escalonador_proc.sv
// Round-robin scheduler between the OS and two user processes.
//   start/quantum/proc_ready : OS request, slice length, loaded processes
//   proc_done/pc_atual       : halt of running process, current processor PC
//   id_proc                  : running context (address-offset select)
//   pc_load/pc_novo          : one-cycle PC load request and value
//   stall/ocioso             : processor freeze, OS running without multitasking
module escalonador_proc
    import escalonador_proc_pkg::*;
(
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    input  logic [7:0]      quantum,
    input  logic [1:0]      proc_ready,
    input  logic            proc_done,
    input  logic [PC_W-1:0] pc_atual,
    output logic [1:0]      id_proc,
    output logic            pc_load,
    output logic [PC_W-1:0] pc_novo,
    output logic            stall,
    output logic            ocioso
);

    estado_t         estado, prox;
    logic [PC_W-1:0] tabela [0:2];
    logic [1:0]      feito;        // bit0 = P1 halted, bit1 = P2 halted
    logic            ptr;          // 0 -> P1 has priority, 1 -> P2
    logic [1:0]      alvo;         // context chosen at the last selection
    logic            causa_done;   // slice ended by halt, not by expiry
    logic            expira;
    logic [1:0]      eleg;
    logic [1:0]      escolha;
    logic [7:0]      q_ef;

    assign q_ef = (quantum == 8'd0) ? 8'd1 : quantum;

    contador_quantum u_contador (
        .clock  (clock),
        .reset  (reset),
        .load   (estado == CARREGA),
        .dec    (estado == EXECUTA),
        .valor  (q_ef),
        .expira (expira)
    );

    always_comb begin
        eleg    = proc_ready & ~feito;
        escolha = ID_SO;
        if (eleg[ptr])
            escolha = ptr ? ID_P2 : ID_P1;
        else if (eleg[~ptr])
            escolha = ptr ? ID_P1 : ID_P2;
    end

    always_comb begin
        prox    = estado;
        pc_load = 1'b0;
        pc_novo = '0;
        stall   = 1'b0;
        ocioso  = 1'b0;
        id_proc = alvo;
        case (estado)
            OCIOSO: begin
                ocioso  = 1'b1;
                id_proc = ID_SO;
                if (start) prox = SELECIONA;
            end
            SELECIONA: begin
                stall = 1'b1;
                prox  = CARREGA;
            end
            CARREGA: begin
                stall   = 1'b1;
                pc_load = 1'b1;
                pc_novo = tabela[alvo];
                prox    = (alvo == ID_SO) ? OCIOSO : EXECUTA;
            end
            EXECUTA: begin
                if (proc_done || expira) prox = SALVA;
            end
            SALVA: begin
                stall = 1'b1;
                prox  = SELECIONA;
            end
            default: prox = OCIOSO;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado     <= OCIOSO;
            for (int i = 0; i < 3; i++) tabela[i] <= '0;
            feito      <= '0;
            ptr        <= 1'b0;
            alvo       <= ID_SO;
            causa_done <= 1'b0;
        end else begin
            estado <= prox;
            case (estado)
                OCIOSO: begin
                    if (start) begin
                        tabela[ID_SO] <= pc_atual;
                        feito         <= '0;
                    end
                end
                SELECIONA: alvo <= escolha;
                // Value from the final executing cycle is what SALVA acts on;
                // halt wins over a coincident expiry.
                EXECUTA:   causa_done <= proc_done;
                SALVA: begin
                    if (causa_done)
                        feito[alvo == ID_P2] <= 1'b1;
                    else
                        tabela[alvo] <= pc_atual;
                    ptr <= (alvo == ID_P1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_escalonador_proc.sv
module tb_escalonador_proc;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [7:0] quantum = 8'd0;
    logic [1:0] proc_ready = 2'b00;
    logic       proc_done = 1'b0;
    logic [8:0] pc_atual = 9'd0;
    logic [1:0] id_proc;
    logic       pc_load;
    logic [8:0] pc_novo;
    logic       stall;
    logic       ocioso;

    escalonador_proc dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .quantum    (quantum),
        .proc_ready (proc_ready),
        .proc_done  (proc_done),
        .pc_atual   (pc_atual),
        .id_proc    (id_proc),
        .pc_load    (pc_load),
        .pc_novo    (pc_novo),
        .stall      (stall),
        .ocioso     (ocioso)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [1:0] id;
        logic [8:0] pc;
        int         run;   // executing cycles expected after this load
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t mk(input logic [1:0] id, input logic [8:0] pc, input int run);
        exp_t e;
        e.id = id; e.pc = pc; e.run = run;
        return e;
    endfunction

    // Load monitor: pops scoreboard on every pc_load, checks slice length
    // of the previous user slice and the stalled switch gap.
    int   run_cnt = 0;
    int   gap_cnt = 0;
    bit   last_user = 0;
    int   last_run = 0;
    always @(negedge clock) begin
        exp_t e;
        if (reset) begin
            run_cnt = 0; gap_cnt = 0; last_user = 0;
        end else begin
            if (!stall && !ocioso) begin run_cnt++; gap_cnt = 0; end
            else if (stall) gap_cnt++;
            else gap_cnt = 0;
            if (pc_load) begin
                if (last_user) begin
                    chk("run_len", run_cnt, last_run);
                    chk("switch_gap", gap_cnt, 3);
                end
                if (sb.size() == 0) begin
                    chk("unexpected_load", {30'd0, id_proc}, 32'hFFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    chk("id_proc", id_proc, e.id);
                    chk("pc_novo", pc_novo, e.pc);
                    chk("load_stall", stall, 1);
                    last_user = (e.id != 2'b00);
                    last_run  = e.run;
                end
                run_cnt = 0;
            end
        end
    end

    task automatic do_reset();
        @(negedge clock); reset = 1'b1;
        @(negedge clock);
        chk("rst_id", id_proc, 0);
        chk("rst_pc_load", pc_load, 0);
        chk("rst_pc_novo", pc_novo, 0);
        chk("rst_stall", stall, 0);
        chk("rst_ocioso", ocioso, 1);
        reset = 1'b0;
    endtask

    task automatic pulse_start(input logic [8:0] pc_start, input logic [8:0] pc_after);
        @(negedge clock); start = 1'b1; pc_atual = pc_start;
        @(negedge clock); start = 1'b0; pc_atual = pc_after;
    endtask

    task automatic wait_load(input string tag);
        bit seen = 0;
        for (int k = 0; k < 60 && !seen; k++) begin
            @(negedge clock);
            if (pc_load) seen = 1;
        end
        chk({tag, "_seen"}, seen, 1);
    endtask

    task automatic check_idle(input string tag);
        @(negedge clock);
        chk({tag, "_ocioso"}, ocioso, 1);
        chk({tag, "_id"}, id_proc, 0);
        chk({tag, "_stall"}, stall, 0);
    endtask

    initial begin
        do_reset();

        // Two ready processes, quantum 4: alternation and PC save/restore.
        quantum = 8'd4; proc_ready = 2'b11;
        sb.push_back(mk(2'b01, 9'h000, 4));
        sb.push_back(mk(2'b10, 9'h000, 4));
        sb.push_back(mk(2'b01, 9'h055, 4));
        sb.push_back(mk(2'b10, 9'h0AA, 4));
        sb.push_back(mk(2'b00, 9'h020, 0));
        pulse_start(9'h020, 9'h055);
        wait_load("a_p1");
        wait_load("a_p2");
        pc_atual = 9'h0AA;
        wait_load("a_p1b");
        wait_load("a_p2b");
        proc_ready = 2'b00;
        wait_load("a_os");
        check_idle("a_end");

        // Reset in SELECIONA, then show the PC table was cleared.
        proc_ready = 2'b11;
        @(negedge clock); start = 1'b1; pc_atual = 9'h020;
        @(negedge clock); start = 1'b0;
        chk("e_sel_stall", stall, 1);
        reset = 1'b1;
        @(negedge clock);
        chk("e_rst_id", id_proc, 0);
        chk("e_rst_stall", stall, 0);
        chk("e_rst_pc_load", pc_load, 0);
        chk("e_rst_ocioso", ocioso, 1);
        chk("e_rst_pc_novo", pc_novo, 0);
        reset = 1'b0;
        quantum = 8'd1; proc_ready = 2'b01;
        sb.push_back(mk(2'b01, 9'h000, 1));
        sb.push_back(mk(2'b00, 9'h020, 0));
        pulse_start(9'h020, 9'h020);
        wait_load("e_p1");
        proc_ready = 2'b00;
        wait_load("e_os");
        check_idle("e_end");

        // Halt at 2nd cycle of a 3-cycle slice -> nothing eligible -> OS.
        do_reset();
        quantum = 8'd3; proc_ready = 2'b01;
        sb.push_back(mk(2'b01, 9'h000, 2));
        sb.push_back(mk(2'b00, 9'h020, 0));
        pulse_start(9'h020, 9'h020);
        wait_load("b_p1");
        @(negedge clock);
        @(negedge clock); proc_done = 1'b1;
        @(negedge clock); proc_done = 1'b0;
        wait_load("b_os");
        check_idle("b_end");

        // Quantum 0 behaves as 1.
        do_reset();
        quantum = 8'd0; proc_ready = 2'b11;
        sb.push_back(mk(2'b01, 9'h000, 1));
        sb.push_back(mk(2'b10, 9'h000, 1));
        sb.push_back(mk(2'b01, 9'h044, 1));
        sb.push_back(mk(2'b00, 9'h033, 0));
        pulse_start(9'h033, 9'h044);
        wait_load("c_p1");
        wait_load("c_p2");
        wait_load("c_p1b");
        proc_ready = 2'b00;
        wait_load("c_os");
        check_idle("c_end");

        // Halt coincident with expiry: marked done, slot left untouched.
        do_reset();
        quantum = 8'd2; proc_ready = 2'b01;
        sb.push_back(mk(2'b01, 9'h000, 2));
        sb.push_back(mk(2'b00, 9'h020, 0));
        pulse_start(9'h020, 9'h077);
        wait_load("d_p1");
        @(negedge clock);
        @(negedge clock); proc_done = 1'b1;
        @(negedge clock); proc_done = 1'b0;
        wait_load("d_os");
        sb.push_back(mk(2'b01, 9'h000, 2));
        sb.push_back(mk(2'b01, 9'h077, 2));
        sb.push_back(mk(2'b00, 9'h020, 0));
        pulse_start(9'h020, 9'h077);
        wait_load("d_p1b");
        wait_load("d_p1c");
        proc_ready = 2'b00;
        wait_load("d_os2");
        check_idle("d_end");

        // Start during EXECUTA is ignored (OS slot and slice length kept).
        do_reset();
        quantum = 8'd3; proc_ready = 2'b01;
        sb.push_back(mk(2'b01, 9'h000, 3));
        sb.push_back(mk(2'b01, 9'h066, 3));
        sb.push_back(mk(2'b00, 9'h020, 0));
        pulse_start(9'h020, 9'h066);
        wait_load("f_p1");
        @(negedge clock); start = 1'b1; pc_atual = 9'h0F0;
        @(negedge clock); start = 1'b0; pc_atual = 9'h066;
        wait_load("f_p1b");
        proc_ready = 2'b00;
        wait_load("f_os");
        check_idle("f_end");

        chk("sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/escalonador_proc.md
ESCALONADOR_PROC -- requirements
Module: escalonador_proc

Interface
REQ-001 SHALL have ports: clock  in  1  system clock, all state on rising edge.
REQ-002 SHALL have ports: reset  in  1  synchronous, active-high; one clock, no other clock domain.
REQ-003 SHALL have ports: start  in  1  OS request to begin round-robin multitasking, one-cycle pulse.
REQ-004 SHALL have ports: quantum  in  8  time slice in cycles; 0 treated as 1.
REQ-005 SHALL have ports: proc_ready  in  2  bit0 = process 1 loaded, bit1 = process 2 loaded.
REQ-006 SHALL have ports: proc_done  in  1  running user process executed halt.
REQ-007 SHALL have ports: pc_atual  in  9  current processor PC.
REQ-008 SHALL have ports: id_proc  out  2  running context: 00 OS, 01 process 1, 10 process 2; drives the address-offset adder.
REQ-009 SHALL have ports: pc_load  out  1  one-cycle pulse, processor loads pc_novo.
REQ-010 SHALL have ports: pc_novo  out  9  PC to load.
REQ-011 SHALL have ports: stall  out  1  processor freezes PC and register writes.
REQ-012 SHALL have ports: ocioso  out  1  high when the OS runs with multitasking off.

Function
REQ-013 SHALL implement FSM states OCIOSO, SELECIONA, CARREGA, EXECUTA, SALVA.
REQ-014 SHALL hold a 3-entry PC table (OS, P1, P2), a done flag per user process and a round-robin pointer (initially P1).
REQ-015 OCIOSO: id_proc=00, stall=0, ocioso=1; on start=1, write pc_atual into OS slot, clear both done flags, go to SELECIONA.
REQ-016 SELECIONA: stall=1; eligible = proc_ready & ~done; choose the pointer process if eligible, else the other if eligible, else target OS; go to CARREGA.
REQ-017 CARREGA: stall=1, pc_load=1 for exactly this cycle, pc_novo = table[target], id_proc = target; load quantum counter; next state EXECUTA for a user target, OCIOSO for OS.
REQ-018 EXECUTA: stall=0; counter decrements each cycle; go to SALVA after exactly max(quantum,1) EXECUTA cycles or on proc_done, whichever comes first.
REQ-019 SALVA: stall=1, PC frozen; if proc_done was the cause, set that process's done flag, else store pc_atual into its slot; point round-robin to the other process; go to SELECIONA.
REQ-020 proc_done and quantum expiry in the same cycle SHALL be treated as proc_done.
REQ-021 Switch overhead SHALL be exactly 3 stalled cycles (SALVA, SELECIONA, CARREGA) between user slices.
REQ-022 proc_ready SHALL be sampled only in SELECIONA; changes mid-slice take effect at the next selection.
REQ-023 start outside OCIOSO SHALL be ignored; start in OCIOSO with no eligible process SHALL yield SELECIONA, CARREGA to OS with pc_novo = saved OS PC, then OCIOSO.
REQ-024 proc_done outside EXECUTA SHALL be ignored.

Reset
REQ-025 Reset SHALL force OCIOSO, id_proc=00, pc_load=0, pc_novo=0, stall=0, ocioso=1, PC table 0, done flags 0, pointer P1, counter 0, on the next edge from any state including mid-switch.

Structure
REQ-026 SHALL place state encoding, ID_SO/ID_P1/ID_P2 constants and PC width (9) in a shared package.
REQ-027 SHALL instantiate one sub-module, contador_quantum (load, decrement, expiry flag).

Verification
REQ-028 Reset, then start with proc_ready=11, quantum=4, pc_atual=0x020 -> OS slot=0x020; CARREGA pulses pc_load with pc_novo=0, id_proc=01; 4 EXECUTA cycles; SALVA stores P1 PC; then id_proc=10.
REQ-029 proc_ready=01, quantum=3, proc_done at 2nd EXECUTA cycle -> done set, SELECIONA finds none eligible, pc_novo=0x020, id_proc=00, then ocioso=1.
REQ-030 quantum=0 -> exactly 1 EXECUTA cycle per slice, alternating 01/10 with 3 stall cycles between.
REQ-031 proc_done coincident with expiry -> process marked done, PC slot unchanged.
REQ-032 reset asserted during SELECIONA -> next cycle id_proc=00, stall=0, pc_load=0, ocioso=1, table cleared.
REQ-033 start pulse during EXECUTA -> no effect on state, counter or table.
